// File: rtl/inv_sbox_if.sv
// Bus bundle for the inverse S-box builder: the forward S-box read port
// and the inverse-lookup request/response port.
// The master side is the inv_sbox block; the slave side is the S-box
// storage together with the decryption datapath.
interface inv_sbox_if;

    // Forward S-box read port
    logic       sbox_rd_en;
    logic [7:0] sbox_addr;
    logic [7:0] sbox_data;

    // Inverse lookup port
    logic       req_valid;
    logic [7:0] req_data;
    logic       resp_valid;
    logic [7:0] resp_data;

    modport master (
        output sbox_rd_en,
        output sbox_addr,
        input  sbox_data,
        input  req_valid,
        input  req_data,
        output resp_valid,
        output resp_data
    );

    modport slave (
        input  sbox_rd_en,
        input  sbox_addr,
        output sbox_data,
        output req_valid,
        output req_data,
        input  resp_valid,
        input  resp_data
    );

endinterface

// File: rtl/inv_sbox.sv
// Inverse S-box builder.
// After the forward S-box is complete, all 256 entries are read back in
// order. Each returned byte is written as inv[S[a]] = a, and a used-flag
// per value catches duplicates. Because exactly 256 entries are written,
// the absence of duplicates is enough to prove the table is a bijection.
// Once the table is built, single-cycle pipelined inverse lookups are
// served until the next reset.
module inv_sbox (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    inv_sbox_if.master bus,
    output logic       done_inv,
    output logic       error
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    localparam logic [7:0] LAST_ADDR = 8'hFF;

    logic [2:0]   r_state;
    logic [2:0]   w_state_nxt;

    // Read side: issued address and strobe
    logic         r_rd_en;
    logic [7:0]   r_addr;

    // Write side: address and valid delayed to line up with sbox_data
    logic         r_wr_valid;
    logic [7:0]   r_wr_addr;

    // One flag per value, set as each value is seen
    logic [255:0] r_used;
    logic [7:0]   r_inv [0:255];

    logic         r_done;
    logic         r_error;
    logic         r_resp_valid;
    logic [7:0]   r_resp_data;

    logic [7:0]   w_sbox_data;
    logic         w_seen;
    logic         w_dup;
    logic         w_wr_en;
    logic         w_lookup;

    assign w_sbox_data = bus.sbox_data;
    assign w_seen      = r_used[w_sbox_data];
    assign w_dup       = r_wr_valid &  w_seen;
    assign w_wr_en     = r_wr_valid & ~w_seen;

    // Lookups are only honoured once the table is known to be good.
    assign w_lookup    = (r_state == S_DONE) & bus.req_valid;

    assign bus.sbox_rd_en = r_rd_en;
    assign bus.sbox_addr  = r_addr;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_data  = r_resp_data;
    assign done_inv       = r_done;
    assign error          = r_error;

    // Next-state logic for the build sequence.
    always_comb begin
        // NOTE: default assignment first so no path leaves the signal
        // unassigned, which would otherwise infer a latch.
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_READ;
                end
            end
            S_READ: begin
                if (r_addr == LAST_ADDR) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // The last entry is checked in this cycle, so its duplicate
                // flag has to be folded in alongside the sticky error.
                if (r_error || w_dup) begin
                    w_state_nxt = S_ERR;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_DONE;
            S_ERR:   w_state_nxt = S_ERR;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, read-address counter and delayed write-side tracking.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            r_state    <= S_IDLE;
            r_rd_en    <= 1'b0;
            r_addr     <= 8'h00;
            r_wr_valid <= 1'b0;
            r_wr_addr  <= 8'h00;
        end else begin
            r_state    <= w_state_nxt;
            r_rd_en    <= (w_state_nxt == S_READ);
            r_wr_valid <= r_rd_en;
            r_wr_addr  <= r_addr;
            // The counter stops at 255 rather than wrapping; READ exits on it.
            if (r_state == S_READ && r_addr != LAST_ADDR) begin
                r_addr <= r_addr + 8'd1;
            end
        end
    end

    // Used-value flags and the sticky status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_used  <= '0;
            r_error <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_used[w_sbox_data] <= 1'b1;
            end
            if (w_dup) begin
                r_error <= 1'b1;
            end
            if (w_state_nxt == S_DONE) begin
                r_done <= 1'b1;
            end
        end
    end

    // Inverse table write port: inv[S[a]] = a for every first-seen value.
    always_ff @(posedge clk) begin
        // NOTE: the table itself has no reset; every entry is rewritten
        // before it can be read, and the used flags carry the real state.
        if (w_wr_en) begin
            r_inv[w_sbox_data] <= r_wr_addr;
        end
    end

    // Pipelined lookup response, one cycle after the request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp_valid <= 1'b0;
            r_resp_data  <= 8'h00;
        end else begin
            r_resp_valid <= w_lookup;
            if (w_lookup) begin
                r_resp_data <= r_inv[bus.req_data];
            end
        end
    end

endmodule

// File: tb/tb_inv_sbox.sv
// Self-checking bench for inv_sbox: a behavioural forward S-box memory,
// table-driven lookup vectors and directed build sequences.
module tb_inv_sbox;

    typedef struct {
        string      name;
        logic [7:0] req;
        logic [7:0] exp;
    } lookup_vec_t;

    logic clk;
    logic rst;
    logic start;
    logic done_inv;
    logic error;

    inv_sbox_if bus ();

    inv_sbox dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus.master),
        .done_inv (done_inv),
        .error    (error)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  fwd [0:255];
    lookup_vec_t vecs [$];

    // Results of the most recent build run (cycle numbers relative to E0).
    int         b_rd_cnt;
    int         b_first_rd;
    int         b_last_rd;
    logic [7:0] b_first_addr;
    int         b_done_cyc;
    int         b_err_cyc;
    int         b_resp_early;
    int         b_first_resp;
    logic [7:0] b_first_resp_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Forward S-box storage model: read data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (bus.sbox_rd_en) begin
            bus.sbox_data <= fwd[bus.sbox_addr];
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst           = 1'b1;
        start         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_data  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic load_identity();
        for (int i = 0; i < 256; i++) fwd[i] = 8'(i);
    endtask

    task automatic load_reversal();
        for (int i = 0; i < 256; i++) fwd[i] = 8'(255 - i);
    endtask

    task automatic load_random_perm();
        logic [7:0] tmp;
        int         j;
        load_identity();
        for (int i = 255; i > 0; i--) begin
            j      = $urandom_range(i, 0);
            tmp    = fwd[i];
            fwd[i] = fwd[j];
            fwd[j] = tmp;
        end
    endtask

    // Pulse start, then observe 262 cycles after the start-sampling edge E0.
    task automatic run_build(input bit hold_req, input logic [7:0] hold_data);
        b_rd_cnt          = 0;
        b_first_rd        = -1;
        b_last_rd         = -1;
        b_first_addr      = 8'hXX;
        b_done_cyc        = -1;
        b_err_cyc         = -1;
        b_resp_early      = 0;
        b_first_resp      = -1;
        b_first_resp_data = 8'h00;
        @(negedge clk);
        start         = 1'b1;
        bus.req_valid = hold_req;
        bus.req_data  = hold_data;
        @(posedge clk);
        for (int c = 1; c <= 262; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (bus.sbox_rd_en) begin
                b_rd_cnt++;
                if (b_first_rd < 0) begin
                    b_first_rd   = c;
                    b_first_addr = bus.sbox_addr;
                end
                b_last_rd = c;
            end
            if (done_inv && b_done_cyc < 0) b_done_cyc = c;
            if (error && b_err_cyc < 0) b_err_cyc = c;
            if (bus.resp_valid) begin
                if (b_done_cyc < 0 || c == b_done_cyc) begin
                    b_resp_early++;
                end else if (b_first_resp < 0) begin
                    b_first_resp      = c;
                    b_first_resp_data = bus.resp_data;
                end
            end
        end
        bus.req_valid = 1'b0;
    endtask

    // Issue every queued vector back-to-back and check each response.
    task automatic apply_vecs();
        if (vecs.size() == 0) return;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_data  = vecs[0].req;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            check({vecs[i].name, "_valid"}, 32'(bus.resp_valid), 32'd1);
            check({vecs[i].name, "_data"},  32'(bus.resp_data),  32'(vecs[i].exp));
            if (i + 1 < vecs.size()) begin
                bus.req_data = vecs[i + 1].req;
            end else begin
                bus.req_valid = 1'b0;
            end
        end
    endtask

    initial begin
        bit         found;
        int         cnt;
        lookup_vec_t id_vecs [3];
        lookup_vec_t rev_vecs [3];

        id_vecs[0]  = '{"id_5a",  8'h5A, 8'h5A};
        id_vecs[1]  = '{"id_00",  8'h00, 8'h00};
        id_vecs[2]  = '{"id_ff",  8'hFF, 8'hFF};
        rev_vecs[0] = '{"rev_00", 8'h00, 8'hFF};
        rev_vecs[1] = '{"rev_ff", 8'hFF, 8'h00};
        rev_vecs[2] = '{"rev_80", 8'h80, 8'h7F};

        rst           = 1'b1;
        start         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_data  = 8'h00;
        load_identity();
        do_reset();

        // Reset values
        check("rst_rd_en",      32'(bus.sbox_rd_en), 32'd0);
        check("rst_addr",       32'(bus.sbox_addr),  32'd0);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_data",  32'(bus.resp_data),  32'd0);
        check("rst_done",       32'(done_inv),       32'd0);
        check("rst_error",      32'(error),          32'd0);

        // Identity table
        run_build(1'b0, 8'h00);
        check("id_rd_cnt",     32'(b_rd_cnt),     32'd256);
        check("id_first_rd",   32'(b_first_rd),   32'd1);
        check("id_first_addr", 32'(b_first_addr), 32'd0);
        check("id_last_rd",    32'(b_last_rd),    32'd256);
        check("id_done_cyc",   32'(b_done_cyc),   32'd258);
        check("id_no_error",   32'(b_err_cyc),    32'hFFFF_FFFF);
        vecs.delete();
        foreach (id_vecs[i]) vecs.push_back(id_vecs[i]);
        apply_vecs();

        // Reversal table with a lookup request held through the whole build
        do_reset();
        load_reversal();
        run_build(1'b1, 8'h00);
        check("rev_done_cyc",        32'(b_done_cyc),        32'd258);
        check("rev_no_error",        32'(b_err_cyc),         32'hFFFF_FFFF);
        check("rev_no_early_resp",   32'(b_resp_early),      32'd0);
        check("rev_first_resp_cyc",  32'(b_first_resp),      32'd259);
        check("rev_first_resp_data", 32'(b_first_resp_data), 32'hFF);
        vecs.delete();
        foreach (rev_vecs[i]) vecs.push_back(rev_vecs[i]);
        apply_vecs();

        // Duplicate table: S[7] = S[100] = 0x33, value 0x34 missing
        do_reset();
        load_identity();
        fwd[7]     = 8'h33;
        fwd[100]   = 8'h33;
        fwd[8'h33] = 8'd7;
        fwd[8'h34] = 8'd100;
        run_build(1'b0, 8'h00);
        check("dup_rd_cnt",   32'(b_rd_cnt),   32'd256);
        check("dup_err_cyc",  32'(b_err_cyc),  32'd103);
        check("dup_no_done",  32'(b_done_cyc), 32'hFFFF_FFFF);
        cnt = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_data  = 8'h33;
        repeat (4) begin
            @(negedge clk);
            if (bus.resp_valid) cnt++;
        end
        bus.req_valid = 1'b0;
        check("dup_no_resp",     32'(cnt),   32'd0);
        check("dup_error_stuck", 32'(error), 32'd1);

        // Reset in the middle of a build, at read address 128
        do_reset();
        load_random_perm();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 300 && !found; c++) begin
            if (bus.sbox_rd_en && bus.sbox_addr == 8'd128) found = 1'b1;
            else @(negedge clk);
        end
        check("abort_reached_128", 32'(found), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_rd_en", 32'(bus.sbox_rd_en), 32'd0);
        check("abort_addr",  32'(bus.sbox_addr),  32'd0);
        check("abort_done",  32'(done_inv),       32'd0);
        check("abort_error", 32'(error),          32'd0);
        rst = 1'b0;

        // Rebuild from scratch with a fresh random permutation
        load_random_perm();
        run_build(1'b0, 8'h00);
        check("perm_first_addr", 32'(b_first_addr), 32'd0);
        check("perm_rd_cnt",     32'(b_rd_cnt),     32'd256);
        check("perm_done_cyc",   32'(b_done_cyc),   32'd258);
        check("perm_no_error",   32'(b_err_cyc),    32'hFFFF_FFFF);
        vecs.delete();
        for (int x = 0; x < 256; x++) vecs.push_back('{"perm", fwd[x], 8'(x)});
        apply_vecs();

        // start held high in DONE must not trigger another build
        cnt = 0;
        @(negedge clk);
        start = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (bus.sbox_rd_en) cnt++;
        end
        check("hold_no_rd_en", 32'(cnt),      32'd0);
        check("hold_done",     32'(done_inv), 32'd1);
        check("hold_error",    32'(error),    32'd0);
        vecs.delete();
        vecs.push_back('{"hold_0",   fwd[0],   8'd0});
        vecs.push_back('{"hold_129", fwd[129], 8'd129});
        vecs.push_back('{"hold_255", fwd[255], 8'd255});
        apply_vecs();
        start = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
